// File: rtl/psum_requantizer.sv
// Two-stage requantizer: per-lane round/arithmetic-shift, then saturate or wrap to DATA_WIDTH.
// Optional ReLU clamp is built when the REQUANT_RELU_EN macro is defined.
module psum_requantizer #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH,
  parameter int LANES      = 4,
  parameter int SEL_WIDTH  = $clog2(ACC_WIDTH)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_we,
  input  logic [SEL_WIDTH-1:0]          cfg_shift,
  input  logic                          cfg_round,
  input  logic                          cfg_sat,
`ifdef REQUANT_RELU_EN
  input  logic                          cfg_relu,
`endif
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*ACC_WIDTH-1:0]    in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*DATA_WIDTH-1:0]   out_data,
  output logic [LANES-1:0]              sat_flag,
  output logic                          busy
);
  localparam int XW = ACC_WIDTH + 1;
  localparam logic signed [XW-1:0] MAX_V = {{(XW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [XW-1:0] MIN_V = {{(XW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic [SEL_WIDTH-1:0]        cfg_shift_q, cfg_shift_d;
  logic                        cfg_round_q, cfg_round_d;
  logic                        cfg_sat_q, cfg_sat_d;
`ifdef REQUANT_RELU_EN
  logic                        cfg_relu_q, cfg_relu_d;
`endif
  logic                        s1_valid_q, s1_valid_d;
  logic [LANES*XW-1:0]         s1_y_q, s1_y_d;
  logic                        s2_valid_q, s2_valid_d;
  logic [LANES*DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [LANES-1:0]            sat_flag_q, sat_flag_d;

  // Valid/ready: a word group moves across a boundary on a cycle where the
  // sender's valid and the receiver's ready are both high; no other cycle.
  logic s2_can_load, s1_adv, s1_load;
  assign s2_can_load = !s2_valid_q || out_ready;
  assign s1_adv      = s1_valid_q && s2_can_load;
  assign in_ready    = !s1_valid_q || s1_adv;
  assign s1_load     = in_valid && in_ready;
  assign busy        = s1_valid_q || s2_valid_q;
  assign out_valid   = s2_valid_q;
  assign out_data    = out_data_q;
  assign sat_flag    = sat_flag_q;

  // Config only changes on an empty pipe, so both stages can read it directly.
  always_comb begin
    cfg_shift_d = cfg_shift_q;
    cfg_round_d = cfg_round_q;
    cfg_sat_d   = cfg_sat_q;
`ifdef REQUANT_RELU_EN
    cfg_relu_d  = cfg_relu_q;
`endif
    if (cfg_we && !busy) begin
      cfg_shift_d = cfg_shift;
      cfg_round_d = cfg_round;
      cfg_sat_d   = cfg_sat;
`ifdef REQUANT_RELU_EN
      cfg_relu_d  = cfg_relu;
`endif
    end
  end

  always_comb begin
    logic signed [XW-1:0] x;
    x          = '0;
    s1_y_d     = s1_y_q;
    s1_valid_d = in_ready ? in_valid : s1_valid_q;
    for (int i = 0; i < LANES; i++) begin
      x = {in_data[i*ACC_WIDTH+ACC_WIDTH-1], in_data[i*ACC_WIDTH +: ACC_WIDTH]};
      if (cfg_round_q && (cfg_shift_q != '0))
        x = x + (XW'(1) << (cfg_shift_q - SEL_WIDTH'(1)));
      if (s1_load) s1_y_d[i*XW +: XW] = x >>> cfg_shift_q;
    end
  end

  always_comb begin
    logic signed [XW-1:0]  y;
    logic [DATA_WIDTH-1:0] lane_o;
    logic                  lane_f;
    y          = '0;
    lane_o     = '0;
    lane_f     = 1'b0;
    out_data_d = out_data_q;
    sat_flag_d = sat_flag_q;
    s2_valid_d = s2_can_load ? s1_valid_q : s2_valid_q;
    for (int i = 0; i < LANES; i++) begin
      y = s1_y_q[i*XW +: XW];
`ifdef REQUANT_RELU_EN
      if (cfg_relu_q && y[XW-1]) y = '0;
`endif
      lane_o = y[DATA_WIDTH-1:0];
      lane_f = 1'b0;
      if (cfg_sat_q && (y > MAX_V)) begin
        lane_o = MAX_V[DATA_WIDTH-1:0];
        lane_f = 1'b1;
      end else if (cfg_sat_q && (y < MIN_V)) begin
        lane_o = MIN_V[DATA_WIDTH-1:0];
        lane_f = 1'b1;
      end
      if (s1_adv) begin
        out_data_d[i*DATA_WIDTH +: DATA_WIDTH] = lane_o;
        sat_flag_d[i] = lane_f;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_shift_q <= '0;
      cfg_round_q <= 1'b0;
      cfg_sat_q   <= 1'b1;
`ifdef REQUANT_RELU_EN
      cfg_relu_q  <= 1'b0;
`endif
      s1_valid_q  <= 1'b0;
      s1_y_q      <= '0;
      s2_valid_q  <= 1'b0;
      out_data_q  <= '0;
      sat_flag_q  <= '0;
    end else begin
      cfg_shift_q <= cfg_shift_d;
      cfg_round_q <= cfg_round_d;
      cfg_sat_q   <= cfg_sat_d;
`ifdef REQUANT_RELU_EN
      cfg_relu_q  <= cfg_relu_d;
`endif
      s1_valid_q  <= s1_valid_d;
      s1_y_q      <= s1_y_d;
      s2_valid_q  <= s2_valid_d;
      out_data_q  <= out_data_d;
      sat_flag_q  <= sat_flag_d;
    end
  end
endmodule

// File: tb/tb_psum_requantizer.sv
// Directed bench for psum_requantizer: vector table, stall burst, config-while-busy,
// mid-stream reset, and the ReLU option when REQUANT_RELU_EN is defined.
module tb_psum_requantizer;
  localparam int DW = 16;
  localparam int AW = 32;
  localparam int L  = 4;
  localparam int SW = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cfg_we = 1'b0;
  logic [SW-1:0]   cfg_shift = '0;
  logic            cfg_round = 1'b0;
  logic            cfg_sat = 1'b1;
`ifdef REQUANT_RELU_EN
  logic            cfg_relu = 1'b0;
`endif
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [L*AW-1:0] in_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [L*DW-1:0] out_data;
  logic [L-1:0]    sat_flag;
  logic            busy;

  int checks = 0;
  int failures = 0;
  logic [L*DW-1:0] exp_q[$];

  typedef struct {
    logic [SW-1:0] shift;
    logic          rnd;
    logic          sat;
    logic [AW-1:0] din;
    logic [DW-1:0] dout;
    logic          flag;
  } vec_t;
  vec_t vecs[17];

  psum_requantizer dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_shift(cfg_shift),
    .cfg_round(cfg_round), .cfg_sat(cfg_sat),
`ifdef REQUANT_RELU_EN
    .cfg_relu(cfg_relu),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sat_flag(sat_flag), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one group; returns at posedge+1 of the transfer edge.
  task automatic send(input logic [L*AW-1:0] d, input logic drop);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("in_ready_wait", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    if (drop) in_valid = 1'b0;
  endtask

  task automatic set_cfg(input logic [SW-1:0] sh, input logic rnd, input logic sat, input logic relu);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("cfg_idle_wait", 64'(busy), 64'd0);
    cfg_we = 1'b1; cfg_shift = sh; cfg_round = rnd; cfg_sat = sat;
`ifdef REQUANT_RELU_EN
    cfg_relu = relu;
`else
    if (relu) $display("note: relu requested in a build without it");
`endif
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  // Single group through an empty pipe with out_ready high; checks 2-cycle latency.
  task automatic run_one(input string name, input int lane, input logic [AW-1:0] din,
                         input logic [DW-1:0] dout, input logic flag);
    logic [L*AW-1:0] d;
    logic [L*DW-1:0] e;
    logic [L-1:0]    f;
    d = '0; e = '0; f = '0;
    d[lane*AW +: AW] = din;
    e[lane*DW +: DW] = dout;
    f[lane] = flag;
    send(d, 1'b1);
    @(negedge clk);
    check({name, "_lat1"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    check({name, "_valid"}, 64'(out_valid), 64'd1);
    check({name, "_data"}, 64'(out_data), 64'(e));
    check({name, "_flag"}, 64'(sat_flag), 64'(f));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [L*DW-1:0] held;
    logic [L*DW-1:0] e;
    logic [L*AW-1:0] d;
    int got;

    vecs[0]  = '{5'd8,  1'b0, 1'b1, 32'h0001_2345, 16'h0123, 1'b0};
    vecs[1]  = '{5'd4,  1'b1, 1'b1, 32'h0000_0018, 16'h0002, 1'b0};
    vecs[2]  = '{5'd4,  1'b1, 1'b1, 32'hFFFF_FFE8, 16'hFFFF, 1'b0};
    vecs[3]  = '{5'd4,  1'b0, 1'b1, 32'hFFFF_FFE8, 16'hFFFE, 1'b0};
    vecs[4]  = '{5'd0,  1'b0, 1'b1, 32'h0001_0000, 16'h7FFF, 1'b1};
    vecs[5]  = '{5'd0,  1'b0, 1'b1, 32'hFFFE_0000, 16'h8000, 1'b1};
    vecs[6]  = '{5'd0,  1'b0, 1'b0, 32'h0001_0000, 16'h0000, 1'b0};
    vecs[7]  = '{5'd0,  1'b0, 1'b0, 32'hFFFE_0000, 16'h0000, 1'b0};
    vecs[8]  = '{5'd31, 1'b1, 1'b1, 32'h7FFF_FFFF, 16'h0001, 1'b0};
    vecs[9]  = '{5'd31, 1'b0, 1'b1, 32'h8000_0000, 16'hFFFF, 1'b0};
    vecs[10] = '{5'd1,  1'b1, 1'b1, 32'hFFFF_FFFF, 16'h0000, 1'b0};
    vecs[11] = '{5'd16, 1'b0, 1'b0, 32'h1234_5678, 16'h1234, 1'b0};
    vecs[12] = '{5'd8,  1'b0, 1'b0, 32'h1234_5678, 16'h3456, 1'b0};
    vecs[13] = '{5'd8,  1'b0, 1'b1, 32'h1234_5678, 16'h7FFF, 1'b1};
    vecs[14] = '{5'd15, 1'b1, 1'b1, 32'h3FFF_C000, 16'h7FFF, 1'b1};
    vecs[15] = '{5'd0,  1'b1, 1'b1, 32'h0000_7FFF, 16'h7FFF, 1'b0};
    vecs[16] = '{5'd0,  1'b0, 1'b1, 32'hFFFF_8000, 16'h8000, 1'b0};

    // Reset state
    #3;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_sat_flag", 64'(sat_flag), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    run_one("rst_cfg_default", 0, 32'h0001_0000, 16'h7FFF, 1'b1);

    // Vector table
    for (int i = 0; i < 17; i++) begin
      set_cfg(vecs[i].shift, vecs[i].rnd, vecs[i].sat, 1'b0);
      run_one($sformatf("vec%0d", i), i % L, vecs[i].din, vecs[i].dout, vecs[i].flag);
    end

    // Burst of 8 with a 3-cycle downstream stall
    set_cfg(5'd0, 1'b0, 1'b0, 1'b0);
    got = 0;
    fork
      begin
        for (int g = 0; g < 8; g++) begin
          for (int ln = 0; ln < L; ln++)
            d[ln*AW +: AW] = 32'h1357_0000 | (g << 8) | (ln << 4) | g;
          send(d, 1'b0);
        end
        in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        held = out_data;
        for (int c = 0; c < 3; c++) begin
          check("stall_in_ready", 64'(in_ready), 64'd0);
          check("stall_out_valid", 64'(out_valid), 64'd1);
          check("stall_hold", 64'(out_data), 64'(held));
          if (c < 2) @(negedge clk);
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
      begin
        for (int c = 0; c < 60 && got < 8; c++) begin
          @(negedge clk);
          if (out_valid && out_ready) begin
            got++;
            if (exp_q.size() == 0) begin
              check("burst_unexpected", 64'(out_data), 64'(~out_data));
            end else begin
              e = exp_q.pop_front();
              check("burst_data", 64'(out_data), 64'(e));
              check("burst_flag", 64'(sat_flag), 64'd0);
            end
          end
          if (in_valid && in_ready) begin
            for (int ln = 0; ln < L; ln++) e[ln*DW +: DW] = in_data[ln*AW +: DW];
            exp_q.push_back(e);
          end
        end
      end
    join
    check("burst_count", 64'(got), 64'd8);
    check("burst_leftover", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;

    // Config attempt while busy must be ignored
    set_cfg(5'd0, 1'b0, 1'b1, 1'b0);
    out_ready = 1'b0;
    send({96'd0, 32'h0000_0100}, 1'b1);
    send({96'd0, 32'h0000_0100}, 1'b1);
    cfg_we = 1'b1; cfg_shift = 5'd2;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    check("busy_full", 64'(busy), 64'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("busy_inflight_valid", 64'(out_valid), 64'd1);
      check("busy_inflight_data", 64'(out_data), 64'h0100);
      @(posedge clk); #1;
    end
    // cfg_we during the last output transfer is also ignored
    send({96'd0, 32'h0000_0100}, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("last_xfer_valid", 64'(out_valid), 64'd1);
    cfg_we = 1'b1; cfg_shift = 5'd3;
    check("last_xfer_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    check("last_xfer_drained", 64'(busy), 64'd0);
    run_one("old_shift", 0, 32'h0000_0100, 16'h0100, 1'b0);
    set_cfg(5'd2, 1'b0, 1'b1, 1'b0);
    run_one("new_shift", 0, 32'h0000_0100, 16'h0040, 1'b0);

`ifdef REQUANT_RELU_EN
    set_cfg(5'd0, 1'b0, 1'b1, 1'b1);
    run_one("relu_neg", 1, 32'hFFFF_0000, 16'h0000, 1'b0);
    run_one("relu_pos_sat", 2, 32'h0001_0000, 16'h7FFF, 1'b1);
`endif

    // Reset in the middle of a stream
    in_valid = 1'b1;
    in_data  = {96'd0, 32'h0000_0055};
    repeat (3) @(negedge clk);
    check("pre_reset_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_reset_valid", 64'(out_valid), 64'd0);
    check("mid_reset_busy", 64'(busy), 64'd0);
    check("mid_reset_data", 64'(out_data), 64'd0);
    in_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    run_one("post_reset_cfg", 3, 32'hFFFE_0000, 16'h8000, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
